// File: rtl/bram_fifo_pkg.sv
// Shared types and constants for the Bram-backed stream FIFO controller.
package bram_fifo_pkg;

  localparam int unsigned StageDepth = 2;

  typedef logic [1:0] stage_cnt_t;

  // level_o must hold RAM depth plus the in-flight read plus the output stage
  function automatic int unsigned level_width(input int unsigned addr_width);
    return addr_width + 2;
  endfunction

endpackage

// File: rtl/bram_fifo_out_stage.sv
// Two-entry in-order output buffer that absorbs the Bram registered read latency.
module bram_fifo_out_stage
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DataWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 capture_i,
  input  logic                 pop_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output stage_cnt_t           cnt_o
);

  logic [DataWidth-1:0] r_head;
  logic [DataWidth-1:0] r_tail;
  stage_cnt_t           r_cnt;

  // Capture into the first free slot; a pop shifts the tail forward
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_head <= {DataWidth{1'b0}};
      r_tail <= {DataWidth{1'b0}};
      r_cnt  <= 2'd0;
    end else if (flush_i) begin
      r_cnt <= 2'd0;
    end else begin
      case ({capture_i, pop_i})
        2'b10: begin
          if (r_cnt == 2'd0) begin
            r_head <= data_i;
          end else begin
            r_tail <= data_i;
          end
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= data_i;
          end else begin
            r_head <= r_tail;
            r_tail <= data_i;
          end
        end
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign data_o = r_head;
  assign cnt_o  = r_cnt;

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Valid/ready FIFO controller around an external dual-port Bram.
// Optional almost-full flag built when BRAM_FIFO_ALMOST_FULL_EN is defined.
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int unsigned DataWidth        = 16,
  parameter int unsigned AddrWidth        = 9,
  parameter int unsigned AlmostFullThresh = 2**AddrWidth - 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              flush_i,
  input  logic                              s_valid_i,
  output logic                              s_ready_o,
  input  logic [DataWidth-1:0]              s_data_i,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic [DataWidth-1:0]              m_data_o,
  output logic [AddrWidth-1:0]              bram_addra_o,
  output logic                              bram_wea_o,
  output logic [DataWidth-1:0]              bram_dina_o,
  output logic [AddrWidth-1:0]              bram_addrb_o,
  input  logic [DataWidth-1:0]              bram_doutb_i,
  output logic [level_width(AddrWidth)-1:0] level_o,
  output logic                              almost_full_o
);

  localparam int unsigned Pw = AddrWidth + 1;
  localparam int unsigned Lw = level_width(AddrWidth);
  localparam logic [Lw-1:0] AfThresh = Lw'(AlmostFullThresh);

  logic [Pw-1:0] r_wr_ptr;
  logic [Pw-1:0] r_rd_ptr;
  logic          r_inflight;
  logic [Lw-1:0] r_level;

  logic [Pw-1:0] w_wr_ptr_nxt;
  logic [Pw-1:0] w_rd_ptr_nxt;
  logic [Pw-1:0] w_ram_cnt_nxt;
  logic          w_inflight_nxt;
  stage_cnt_t    w_stage_cnt;
  stage_cnt_t    w_stage_cnt_nxt;
  logic [Lw-1:0] w_level_nxt;
  logic [2:0]    w_pend;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_issue;
  logic          w_capture;

  // Pointer MSBs differ with equal low bits only when the RAM is full
  assign w_full  = (r_wr_ptr[AddrWidth] != r_rd_ptr[AddrWidth]) &&
                   (r_wr_ptr[AddrWidth-1:0] == r_rd_ptr[AddrWidth-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign s_ready_o = ~w_full;
  assign w_push    = s_valid_i & ~w_full & ~flush_i & rst_ni;
  assign m_valid_o = (w_stage_cnt != 2'd0);
  assign w_pop     = m_valid_o & m_ready_i;

  // Words the stage will hold once in-flight data lands and this cycle's pop leaves
  assign w_pend    = {1'b0, w_stage_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = ~w_empty & (w_pend < 3'(StageDepth));
  assign w_capture = r_inflight & ~flush_i;

  assign bram_wea_o   = w_push;
  assign bram_addra_o = r_wr_ptr[AddrWidth-1:0];
  assign bram_dina_o  = s_data_i;
  assign bram_addrb_o = r_rd_ptr[AddrWidth-1:0];

  // Next pointer, in-flight and stage occupancy; flush wins over push and pop
  always_comb begin
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_inflight_nxt  = r_inflight;
    w_stage_cnt_nxt = w_stage_cnt;
    if (flush_i) begin
      w_wr_ptr_nxt    = {Pw{1'b0}};
      w_rd_ptr_nxt    = {Pw{1'b0}};
      w_inflight_nxt  = 1'b0;
      w_stage_cnt_nxt = 2'd0;
    end else begin
      w_wr_ptr_nxt    = r_wr_ptr + {{(Pw-1){1'b0}}, w_push};
      w_rd_ptr_nxt    = r_rd_ptr + {{(Pw-1){1'b0}}, w_issue};
      w_inflight_nxt  = w_issue;
      w_stage_cnt_nxt = w_stage_cnt + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign w_ram_cnt_nxt = w_wr_ptr_nxt - w_rd_ptr_nxt;
  assign w_level_nxt   = {1'b0, w_ram_cnt_nxt} + {{(Lw-1){1'b0}}, w_inflight_nxt} +
                         {{(Lw-2){1'b0}}, w_stage_cnt_nxt};

  // Pointer, in-flight flag and level registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= {Pw{1'b0}};
      r_rd_ptr   <= {Pw{1'b0}};
      r_inflight <= 1'b0;
      r_level    <= {Lw{1'b0}};
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_inflight <= w_inflight_nxt;
      r_level    <= w_level_nxt;
    end
  end

  assign level_o = r_level;

  bram_fifo_out_stage #(
    .DataWidth (DataWidth)
  ) u_out_stage (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .capture_i (w_capture),
    .pop_i     (w_pop),
    .data_i    (bram_doutb_i),
    .data_o    (m_data_o),
    .cnt_o     (w_stage_cnt)
  );

`ifdef BRAM_FIFO_ALMOST_FULL_EN
  logic r_almost_full;

  // Almost-full tracks the level after this edge, like level_o
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_level_nxt >= AfThresh);
    end
  end

  assign almost_full_o = r_almost_full;
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^AfThresh;
  assign almost_full_o   = 1'b0;
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Directed self-checking bench for bram_fifo_ctrl with a behavioural Bram model.
module tb_bram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] s_data = 16'h0000;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic [3:0]  addra;
  logic        wea;
  logic [15:0] dina;
  logic [3:0]  addrb;
  logic [15:0] doutb;
  logic [5:0]  level;
  logic        afull;

  logic [15:0] mem [16];

  int n_total = 0;
  int n_bad   = 0;
  int n_push  = 0;
  int m_cnt   = 0;
  logic mon_en = 1'b0;
  logic prev_stall = 1'b0;
  logic [15:0] prev_data = 16'h0000;
  logic [15:0] q[$];

  always #5 clk = ~clk;

  bram_fifo_ctrl #(
    .DataWidth        (16),
    .AddrWidth        (4),
    .AlmostFullThresh (12)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .flush_i       (flush),
    .s_valid_i     (s_valid),
    .s_ready_o     (s_ready),
    .s_data_i      (s_data),
    .m_valid_o     (m_valid),
    .m_ready_i     (m_ready),
    .m_data_o      (m_data),
    .bram_addra_o  (addra),
    .bram_wea_o    (wea),
    .bram_dina_o   (dina),
    .bram_addrb_o  (addrb),
    .bram_doutb_i  (doutb),
    .level_o       (level),
    .almost_full_o (afull)
  );

  // Bram model: write port A, registered read on port B
  always @(posedge clk) begin
    if (wea) mem[addra] <= dina;
    doutb <= mem[addrb];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: level, almost-full, data order and stall stability every cycle
  always @(negedge clk) begin
    if (!mon_en) begin
      q.delete();
      m_cnt = 0;
      prev_stall = 1'b0;
    end else begin
      chk("level", 32'(level), 32'(m_cnt));
`ifdef BRAM_FIFO_ALMOST_FULL_EN
      chk("afull", 32'(afull), 32'(m_cnt >= 12));
`else
      chk("afull", 32'(afull), 32'd0);
`endif
      if (prev_stall) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", 32'(m_data), 32'(prev_data));
      end
      prev_stall = m_valid & ~m_ready & ~flush;
      prev_data  = m_data;
      if (flush) begin
        q.delete();
        m_cnt = 0;
      end else begin
        if (m_valid && m_ready) begin
          chk("pop_nonempty", 32'(q.size() > 0), 32'd1);
          if (q.size() > 0) chk("data", 32'(m_data), 32'(q.pop_front()));
          m_cnt--;
        end
        if (s_valid && s_ready) begin
          q.push_back(s_data);
          m_cnt++;
          n_push++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mvalid"}, 32'(m_valid), 32'd0);
    chk({tag, "_sready"}, 32'(s_ready), 32'd1);
    chk({tag, "_level"}, 32'(level), 32'd0);
    chk({tag, "_afull"}, 32'(afull), 32'd0);
    chk({tag, "_wea"}, 32'(wea), 32'd0);
    chk({tag, "_addra"}, 32'(addra), 32'd0);
    chk({tag, "_addrb"}, 32'(addrb), 32'd0);
  endtask

  initial begin
    s_valid = 1'b1;
    #1;
    chk_reset_vals("rst");
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // Flow-through latency
    s_valid = 1'b1; s_data = 16'h1234; m_ready = 1'b1;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("ft_n0_valid", 32'(m_valid), 32'd0);
    chk("ft_n0_level", 32'(level), 32'd1);
    @(negedge clk);
    chk("ft_n1_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("ft_n2_valid", 32'(m_valid), 32'd1);
    chk("ft_n2_data", 32'(m_data), 32'h1234);
    @(negedge clk);
    chk("ft_after_pop_level", 32'(level), 32'd0);
    chk("ft_after_pop_valid", 32'(m_valid), 32'd0);
    step();

    // Fill to capacity then drain
    m_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      s_valid = 1'b1; s_data = 16'(i);
      @(negedge clk);
      chk("fill_ready", 32'(s_ready), 32'd1);
      step();
    end
    s_data = 16'h0099;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("full_ready", 32'(s_ready), 32'd0);
      chk("full_level", 32'(level), 32'd18);
    end
    step();
    s_valid = 1'b0; m_ready = 1'b1;
    step();
    @(negedge clk);
    chk("drain_ready", 32'(s_ready), 32'd1);
    for (int c = 0; c < 40 && level != 6'd0; c++) step();
    chk("drain_level", 32'(level), 32'd0);
    step();

    // Continuous stream, no bubbles
    m_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      s_valid = 1'b1; s_data = 16'(i + 16'h0400);
      @(negedge clk);
      if (i >= 3) begin
        chk("stream_valid", 32'(m_valid), 32'd1);
        chk("stream_data", 32'(m_data), 32'(i - 3 + 16'h0400));
      end
      step();
    end
    s_valid = 1'b0;
    for (int c = 0; c < 10 && level != 6'd0; c++) step();
    chk("stream_level", 32'(level), 32'd0);

    // Random traffic with pointer wrap
    n_push = 0;
    for (int c = 0; c < 40000 && n_push < 5000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 16'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      step();
    end
    s_valid = 1'b0; m_ready = 1'b1;
    chk("rand_pushes", 32'(n_push >= 5000), 32'd1);
    for (int c = 0; c < 40 && level != 6'd0; c++) step();
    chk("rand_level", 32'(level), 32'd0);

    // Flush right after a read issue with five words held
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'hA000 + 16'(i);
      step();
    end
    s_valid = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("fl_pre_level", 32'(level), 32'd5);
    chk("fl_pre_data", 32'(m_data), 32'hA000);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0; flush = 1'b1; s_valid = 1'b1; s_data = 16'hDEAD;
    step();
    flush = 1'b0; s_valid = 1'b0;
    @(negedge clk);
    chk("fl_level", 32'(level), 32'd0);
    chk("fl_valid", 32'(m_valid), 32'd0);
    s_valid = 1'b1; s_data = 16'hBEEF;
    step();
    s_valid = 1'b0;
    @(negedge clk);
    chk("fl_stale_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("fl_p1_valid", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("fl_p2_valid", 32'(m_valid), 32'd1);
    chk("fl_p2_data", 32'(m_data), 32'hBEEF);
    m_ready = 1'b1;
    repeat (3) step();

    // Asynchronous reset mid-stream
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_data = 16'hC000 + 16'(i);
      step();
    end
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    step();
    rst_n = 1'b1; mon_en = 1'b1; m_ready = 1'b1;
    s_valid = 1'b1; s_data = 16'h5A5A;
    step();
    s_data = 16'h6B6B;
    step();
    s_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    chk("rst_first_valid", 32'(m_valid), 32'd1);
    chk("rst_first_data", 32'(m_data), 32'h5A5A);
    repeat (5) step();
    chk("end_level", 32'(level), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
